// File: rtl/reg_dump_pkg.sv
// Shared types and default widths for the register-dump scanner.
package reg_dump_pkg;

   localparam int unsigned REG_W_DEF  = 32;
   localparam int unsigned ADDR_W_DEF = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage : reg_dump_pkg

// File: rtl/sat_cycle_counter.sv
// Saturating cycle counter with synchronous reset and a terminal-value compare.
module sat_cycle_counter #(
   parameter int unsigned      CNT_W = 16,
   parameter logic [CNT_W-1:0] TERM  = '1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             term_c_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Stop at all-ones so the count never wraps back into the trigger window.
   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o    = cnt_q;
   assign term_c_o = (cnt_q == TERM);

endmodule : sat_cycle_counter

// File: rtl/reg_dump_scanner.sv
// Walks the CPU register file after a cycle budget or a start pulse and emits (index, value) beats.
// Optional running checksum of accepted beats: define REG_DUMP_CHECKSUM_EN.
module reg_dump_scanner
   import reg_dump_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 13,
   parameter int unsigned REG_W       = REG_W_DEF,
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned CYCLE_LIMIT = 25,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic [ADDR_W-1:0] rf_addr_o,
   input  logic [REG_W-1:0]  rf_data_i,
   output logic              dump_valid_o,
   input  logic              dump_ready_i,
   output logic [ADDR_W-1:0] dump_idx_o,
   output logic [REG_W-1:0]  dump_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  cyc_cnt_o,
   output logic [REG_W-1:0]  checksum_o
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
   localparam logic [CNT_W-1:0]  TRIG_CNT = CNT_W'(CYCLE_LIMIT - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] didx_q, didx_d;
   logic [REG_W-1:0]  ddata_q, ddata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              trig_c;
   logic              hs_c;

   sat_cycle_counter #(
      .CNT_W (CNT_W),
      .TERM  (TRIG_CNT)
   ) u_cyc_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (1'b1),
      .cnt_o    (cyc_cnt_o),
      .term_c_o (trig_c)
   );

   assign hs_c = (state_q == HOLD) && valid_q && dump_ready_i;

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      didx_d  = didx_q;
      ddata_d = ddata_q;
      busy_d  = busy_q;
      done_d  = done_q;
      case (state_q)
         IDLE: begin
            if (start_i || trig_c) begin
               state_d = SCAN;
               busy_d  = 1'b1;
            end
         end
         SCAN: begin
            ddata_d = rf_data_i;
            didx_d  = idx_q;
            valid_d = 1'b1;
            state_d = HOLD;
         end
         HOLD: begin
            if (hs_c) begin
               valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = SCAN;
               end
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         valid_q <= 1'b0;
         didx_q  <= '0;
         ddata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         didx_q  <= didx_d;
         ddata_q <= ddata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef REG_DUMP_CHECKSUM_EN
   logic [REG_W-1:0] csum_q;
   logic [REG_W-1:0] csum_d;

   // Accumulate only beats the consumer actually took.
   always_comb begin
      csum_d = csum_q;
      if (hs_c) begin
         csum_d = csum_q + ddata_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign checksum_o = csum_q;
`else
   assign checksum_o = '0;
`endif

   assign rf_addr_o    = idx_q;
   assign dump_valid_o = valid_q;
   assign dump_idx_o   = didx_q;
   assign dump_data_o  = ddata_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule : reg_dump_scanner

// File: doc/reg_dump_scanner.md
Name: reg_dump_scanner

Overview:
- Post-run result collector that sits directly downstream of simple_single_cpu.
- After a fixed cycle budget, or on an explicit start, it walks the CPU register file through a dedicated combinational read port.
- Each register is emitted as an (index, value) beat on a valid/ready stream, which feeds the result logger/file writer.
- It replaces hierarchical peeking into the register file with a synthesizable scan path.

Parameters:
- NUM_REGS, 13, number of registers dumped, r0..r(NUM_REGS-1); legal range 1..32.
- REG_W, 32, register data width.
- ADDR_W, 5, register-file address width.
- CYCLE_LIMIT, 25, auto-trigger point in cycles after reset release; legal range 1..2^CNT_W-1.
- CNT_W, 16, cycle counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  manual trigger; sampled only in IDLE.
- rf_addr_o  out  ADDR_W  register-file read address.
- rf_data_i  in  REG_W  register-file read data; combinational, same cycle as rf_addr_o.
- dump_valid_o  out  1  beat valid.
- dump_ready_i  in  1  consumer ready.
- dump_idx_o  out  ADDR_W  register index of the current beat.
- dump_data_o  out  REG_W  register value of the current beat.
- busy_o  out  1  high in SCAN or HOLD.
- done_o  out  1  dump complete; sticky until reset.
- cyc_cnt_o  out  CNT_W  cycles elapsed since reset release; saturates at all-ones.
- checksum_o  out  REG_W  running checksum (see Optional Feature).

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE, idx=0, cyc_cnt_o=0.
  - dump_valid_o=0, dump_idx_o=0, dump_data_o=0, busy_o=0, done_o=0, checksum_o=0.
  - Reset takes priority over every other event, including mid-scan: an open beat is dropped without a handshake.
- cyc_cnt_o increments by 1 every non-reset cycle in every state and saturates; it never wraps.
- rf_addr_o = idx (zero-extended), combinational from the idx register.
- States and transitions:
  - IDLE -> SCAN when start_i=1, or when cyc_cnt_o==CYCLE_LIMIT-1 (the counter reads CYCLE_LIMIT on the same edge).
  - If both triggers occur in the same cycle: a single transition.
  - SCAN, one cycle: dump_data_o<=rf_data_i, dump_idx_o<=idx, dump_valid_o<=1; -> HOLD.
  - HOLD: hold valid, idx and data stable while dump_ready_i=0.
  - HOLD on the handshake (valid & ready):
    - dump_valid_o<=0;
    - if idx==NUM_REGS-1 -> DONE;
    - else idx<=idx+1 and -> SCAN.
  - DONE: done_o=1, busy_o=0; terminal until reset. start_i is ignored, and the auto-trigger never refires.
- start_i outside IDLE is ignored.
- Throughput: one beat per 2 cycles when ready is held high.
- Latency: the first dump_valid_o rises 2 edges after the trigger cycle.
- Total dump time with ready=1: 2*NUM_REGS cycles from the trigger to done_o.
- Register values are sampled in SCAN, not at the trigger. CPU writes landing between beats are reflected in the dump (documented behaviour).

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- With the macro:
  - checksum_o <= checksum_o + dump_data_o, mod 2^REG_W, on each accepted beat.
  - Cleared to 0 by reset only.
- Without the macro: checksum_o is tied to 0 and no adder is generated.

Decomposition:
- Package reg_dump_pkg holds:
  - the state enum (IDLE, SCAN, HOLD, DONE);
  - default width constants REG_W_DEF=32, ADDR_W_DEF=5.
- Sub-module sat_cycle_counter (CNT_W): enable, synchronous reset, saturating count, terminal-compare output. It is reused by the testbench end-of-run logic.

Test Plan:
- Reset check: hold rst_i high for 3 cycles with ready=1 -> all outputs 0, state IDLE; cyc_cnt_o reads 1 one cycle after release.
- Auto-trigger: preload register k = 3k for k=0..12, ready=1.
  - Expected: 13 beats (idx 0..12, data 0,3,...,36), valid pulsing every 2nd cycle.
  - Expected: done_o high 26 cycles after cyc_cnt_o==25.
- Backpressure: drop ready for 3 cycles on beat idx=4 -> valid, idx=4 and data=12 held stable; the beat is accepted exactly once and idx=5 follows.
- Early start: pulse start_i at cycle 5 -> the dump runs immediately.
  - Expected: no second dump at cycle 25.
  - Expected: start_i pulsed in DONE is ignored.
- Mid-scan reset: assert rst_i while in HOLD at idx=7 -> next cycle valid=0, idx=0, busy=0.
  - Expected: after release, a fresh auto-trigger at cyc_cnt_o==25 dumps all 13 registers.
- With REG_DUMP_CHECKSUM_EN: full dump of the pattern above -> checksum_o=234 (3*78). Without the macro -> checksum_o=0 throughout.
